// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, receiver state encoding and
// the expected-parity helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Parity bit that a correct frame carries, given the XOR of its data bits.
  function automatic logic parity_expect(input logic data_xor, input int unsigned mode);
    logic bit_out;
    case (mode)
      PAR_EVEN: bit_out = data_xor;
      PAR_ODD:  bit_out = ~data_xor;
      default:  bit_out = 1'b0;
    endcase
    return bit_out;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// DIV-period bit timer. A restart pulse marks cycle 0 of a bit train; tick then
// fires in the middle of every bit period (cycles DIV/2, DIV/2+DIV, ...).
module uart_bit_timer #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count cycles since restart modulo DIV; restart cycle is cycle 0, so the next cycle reads 1.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The count is stale during the restart cycle itself, so tick is masked there.
  assign tick = (cnt == HALF) && !restart;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, detects the start edge, samples each bit at
// mid-period, checks parity and stop bit and delivers the word with a valid strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 10,
  parameter int unsigned PAR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         par_err,
  output logic         frm_err,
  output logic         busy
);

  localparam int unsigned IW = $clog2(W + 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(W - 1);

  logic [1:0]    sync;
  logic          rxs;
  logic          rxs_prev;
  logic          fall;
  logic          restart;
  logic          tick;
  rx_state_e     state;
  rx_state_e     state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shift_in;
  logic          par_bad;

  // Two-flop synchronizer plus one delayed copy for edge detection; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      rxs_prev <= 1'b1;
    end else begin
      sync     <= {sync[0], rx};
      rxs_prev <= rxs;
    end
  end

  assign rxs     = sync[1];
  assign fall    = rxs_prev & ~rxs;
  assign restart = (state == ST_IDLE) && fall;

  uart_bit_timer #(.DIV(DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every transition other than BREAK exit happens on a mid-bit tick.
  // NOTE: state_next gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (fall) state_next = ST_START;
      ST_START:  if (tick) state_next = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && idx == LAST_BIT) state_next = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_next = ST_STOP;
      ST_STOP:   if (tick) state_next = rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxs) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Shift the new bit in at the MSB end so the first data bit ends up at the LSB.
  always_comb begin
    shift_in        = shreg >> 1;
    shift_in[W-1]   = rxs;
  end

  // Datapath: bit index, shift register, parity check and the delivered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) idx <= '0;
        end
        ST_DATA: begin
          if (tick) begin
            shreg <= shift_in;
            idx   <= idx + IW'(1);
          end
        end
        ST_PARITY: begin
          if (tick) par_bad <= rxs ^ parity_expect(^shreg, PAR);
        end
        ST_STOP: begin
          if (tick) begin
            valid   <= 1'b1;
            data    <= shreg;
            par_err <= (PAR != PAR_NONE) && par_bad;
            frm_err <= ~rxs;
          end
        end
        default: ;
      endcase
    end
  end

  // Busy covers the frame body, from the confirmed start bit until the word is delivered.
  assign busy = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive stage of the UART link. It sits directly downstream of the transmitter's serial output and upstream of the receive-side cell store. It deserializes one frame into a W-bit word, checks the optional parity bit and the stop bit, and presents the word with a one-cycle valid strobe plus error flags. Bit timing uses the same DIV/PAR parameters as the transmitter.

Parameters:
W, 8, data bits per frame; legal range 1..32.
DIV, 10, clk cycles per bit; minimum 4.
PAR, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
rx  in  1  serial line. Idles high. Asynchronous to clk.
data  out  W  last received word, LSB = first data bit; holds until the next frame completes.
valid  out  1  one-cycle pulse: data, par_err and frm_err are updated this cycle.
par_err  out  1  parity mismatch on the frame just delivered; always 0 when PAR=0.
frm_err  out  1  stop bit sampled low on the frame just delivered.
busy  out  1  high from the accepted start bit until valid.

Behaviour:
- Frame format: start bit 0; W data bits, LSB first; parity bit if PAR!=0; one stop bit 1.
- rx passes through a 2-flop synchronizer, which adds 2 cycles of latency. All timing below refers to the synchronized line rxs.
- Reset: data=0, valid=0, par_err=0, frm_err=0, busy=0, state=IDLE, counters=0. Synchronizer flops reset to 1.
- State machine:
  - IDLE: a high-to-low transition on rxs defines cycle 0 → START, and the bit counter is cleared.
  - START: at cycle H=DIV/2 (floor), sample rxs.
    - If rxs is 1, it is a false start → IDLE. busy is never asserted.
    - If rxs is 0 → DATA. busy goes high from this cycle.
  - DATA: bit k (k=0..W-1) is sampled at cycle H+(k+1)*DIV and shifted in LSB-first. After bit W-1 → PARITY if PAR!=0, else STOP.
  - PARITY: sample at cycle H+(W+1)*DIV. Expected bit = XOR of the data bits for even parity, inverted for odd parity.
  - STOP: sample at cycle H+(W+1+P)*DIV, where P = (PAR!=0). On the next cycle: valid=1, data=shift register, par_err and frm_err are updated, busy=0.
    - If the stop sample is 1 → IDLE.
    - If the stop sample is 0 → BREAK.
  - BREAK: wait for rxs=1, then → IDLE. No new start bit is accepted while in BREAK.
- Error flags: par_err and frm_err are registered with data and hold until the next valid. valid is asserted even when an error is flagged.
- Back-to-back frames: a start edge arriving in the cycle right after the stop sample must be detected. IDLE is entered in time for that.
- rx changes between sample points are ignored. There is no majority vote.
- rst asserted mid-frame: the frame is aborted, no valid is produced, and all outputs return to their reset values on the next edge.
- Counter width: clog2(DIV) bits for the bit timer and clog2(W+2) bits for the bit index. There is no overflow at maximum parameters.

Decomposition:
- uart_pkg holds the PAR_NONE/PAR_EVEN/PAR_ODD constants and the rx state encoding (IDLE, START, DATA, PARITY, STOP, BREAK). The transmitter shares the same parity constants.
- One sub-module, uart_bit_timer: a DIV-period counter with a restart input and a mid-bit tick output. It is reusable by the transmitter.

Test Plan (W=11, DIV=10, PAR=1 unless stated):
1. Send 1365 (0x555) with parity bit 0 and a good stop bit → valid pulses once; data=1365, par_err=0, frm_err=0. busy is high across the frame.
2. Send 682 (0x2AA) with parity bit 1, immediately followed by 1365 with no idle gap → two valid pulses exactly (1+11+1+1)*10=140 cycles apart, data 682 then 1365, no errors.
3. Send 682 with parity bit 0 → data=682, par_err=1. Repeat with PAR=2 and parity bit 0 → par_err=0.
4. Send 1365 with the stop bit held low for 30 cycles, then a valid frame of 1 → first frame: frm_err=1. No start is accepted until rx goes high. Second frame: data=1, frm_err=0.
5. Drive rx low for 3 cycles only → busy stays 0 and no valid is produced. A frame started afterwards is received correctly.
6. Assert rst at data bit 5 of a frame → no valid; all outputs are 0 on the next edge. The next full frame of 4 is received with data=4.
